// File: rtl/operand_fetch_seq_pkg.sv
// Shared widths, FSM state encoding and the read-capture forwarding rule
// for the operand fetch sequencer.
package operand_fetch_seq_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Register file returns stale data on a same-cycle write, so forward the
  // snooped write data; x0 always reads as zero.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rdata,
    input logic              wen,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (addr == {ADDR_W{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if (wen && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = rdata;
    end
    return val;
  endfunction

endpackage

// File: rtl/operand_fetch_seq_if.sv
// Request, register-file read, write-back snoop and response signals of the
// operand fetch sequencer; slave is the sequencer, master its environment.
interface operand_fetch_seq_if;
  import operand_fetch_seq_pkg::*;

  logic              req_val;
  logic              req_rdy;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic              req_two;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              wb_wen;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              resp_val;
  logic              resp_rdy;
  logic [DATA_W-1:0] resp_op1;
  logic [DATA_W-1:0] resp_op2;

  modport slave (
    input  req_val, req_rs1, req_rs2, req_two, rf_rdata,
    input  wb_wen, wb_waddr, wb_wdata, resp_rdy,
    output req_rdy, rf_raddr, resp_val, resp_op1, resp_op2
  );

  modport master (
    output req_val, req_rs1, req_rs2, req_two, rf_rdata,
    output wb_wen, wb_waddr, wb_wdata, resp_rdy,
    input  req_rdy, rf_raddr, resp_val, resp_op1, resp_op2
  );

endinterface

// File: rtl/operand_fetch_seq.sv
// Sequences one or two register-file reads per request, forwarding snooped
// write-back data, and holds the operands until the consumer takes them.
module operand_fetch_seq
  import operand_fetch_seq_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  operand_fetch_seq_if.slave  bus
);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] rs1_r, rs1_s, rs2_r, rs2_s, raddr_r, raddr_s;
  logic              two_r, two_s;
  logic [DATA_W-1:0] op1_r, op1_s, op2_r, op2_s;
  logic              rdy_r, val_r;
  logic              hit1_s, hit2_s;

  // Write-back hits against the latched sources while operands are held.
  always_comb begin
    hit1_s = bus.wb_wen && (bus.wb_waddr != {ADDR_W{1'b0}}) && (bus.wb_waddr == rs1_r);
    hit2_s = bus.wb_wen && two_r && (bus.wb_waddr != {ADDR_W{1'b0}}) && (bus.wb_waddr == rs2_r);
  end

  // Next-state, latched fields and operand capture.
  always_comb begin
    state_s = state_r;
    rs1_s   = rs1_r;
    rs2_s   = rs2_r;
    two_s   = two_r;
    op1_s   = op1_r;
    op2_s   = op2_r;
    case (state_r)
      IDLE: begin
        if (bus.req_val) begin
          state_s = RD1;
          rs1_s   = bus.req_rs1;
          rs2_s   = bus.req_rs2;
          two_s   = bus.req_two;
        end else begin
          state_s = IDLE;
        end
      end
      RD1: begin
        op1_s = fwd_read(rs1_r, bus.rf_rdata, bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
        if (two_r) begin
          state_s = RD2;
        end else begin
          state_s = RESP;
          op2_s   = {DATA_W{1'b0}};
        end
      end
      RD2: begin
        op2_s   = fwd_read(rs2_r, bus.rf_rdata, bus.wb_wen, bus.wb_waddr, bus.wb_wdata);
        state_s = RESP;
      end
      RESP: begin
        if (hit1_s) begin
          op1_s = bus.wb_wdata;
        end else begin
          op1_s = op1_r;
        end
        if (hit2_s) begin
          op2_s = bus.wb_wdata;
        end else begin
          op2_s = op2_r;
        end
        if (bus.resp_rdy) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Read address for the upcoming cycle, so rf_raddr comes straight from a flop.
  always_comb begin
    case (state_s)
      RD1:     raddr_s = rs1_s;
      RD2:     raddr_s = rs2_s;
      default: raddr_s = {ADDR_W{1'b0}};
    endcase
  end

  // State, latched request fields, operands and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      rs1_r   <= {ADDR_W{1'b0}};
      rs2_r   <= {ADDR_W{1'b0}};
      two_r   <= 1'b0;
      op1_r   <= {DATA_W{1'b0}};
      op2_r   <= {DATA_W{1'b0}};
      raddr_r <= {ADDR_W{1'b0}};
      rdy_r   <= 1'b1;
      val_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      rs1_r   <= rs1_s;
      rs2_r   <= rs2_s;
      two_r   <= two_s;
      op1_r   <= op1_s;
      op2_r   <= op2_s;
      raddr_r <= raddr_s;
      rdy_r   <= (state_s == IDLE);
      val_r   <= (state_s == RESP);
    end
  end

  assign bus.req_rdy  = rdy_r;
  assign bus.resp_val = val_r;
  assign bus.rf_raddr = raddr_r;
  assign bus.resp_op1 = op1_r;
  assign bus.resp_op2 = op2_r;

endmodule

// File: doc/operand_fetch_seq.md
OPERAND_FETCH_SEQ -- requirements
Module: operand_fetch_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 req_val  input  1  source-read request valid.
REQ-003 req_rdy  output  1  request accepted when req_val and req_rdy are both high.
REQ-004 req_rs1  input  5  first source register address.
REQ-005 req_rs2  input  5  second source register address.
REQ-006 req_two  input  1  1 = two sources needed; 0 = rs1 only.
REQ-007 rf_raddr  output  5  drives the register file read address.
REQ-008 rf_rdata  input  32  register file read data (combinational, returns old data on same-cycle write).
REQ-009 wb_wen, wb_waddr, wb_wdata  input  1/5/32  snoop of the register file write port.
REQ-010 resp_val  output  1  operands valid.
REQ-011 resp_rdy  input  1  consumer accepts operands when resp_val and resp_rdy are both high.
REQ-012 resp_op1, resp_op2  output  32/32  captured source operands.

Function
REQ-013 FSM states SHALL be IDLE, RD1, RD2, RESP.
REQ-014 req_rdy SHALL be 1 only in IDLE; on accept, the block SHALL latch rs1, rs2 and two, then go to RD1.
REQ-015 In RD1, rf_raddr SHALL equal latched rs1 and op1 SHALL be captured at the clock edge; next state SHALL be RD2 if two=1, else RESP with op2=0.
REQ-016 In RD2, rf_raddr SHALL equal latched rs2 and op2 SHALL be captured; next state SHALL be RESP.
REQ-017 In IDLE and RESP, rf_raddr SHALL be 0.
REQ-018 Capture bypass: if wb_wen=1, wb_waddr equals the address being read and that address is nonzero, the captured value SHALL be wb_wdata; otherwise it SHALL be rf_rdata.
REQ-019 Reads of register 0 SHALL capture 0 regardless of wb activity.
REQ-020 In RESP, resp_val SHALL be 1; a write snooped while in RESP to a nonzero latched rs1 (or rs2 when two=1) SHALL update op1 (op2) at that edge.
REQ-021 When rs1 equals rs2, a RESP-state write SHALL update both operands.
REQ-022 On resp_val and resp_rdy, the next state SHALL be IDLE; no new request SHALL be accepted in that same cycle.
REQ-023 Latency: accept edge at cycle 0; resp_val SHALL be high in cycle 2 (two=0) or cycle 3 (two=1).
REQ-024 resp_op1 and resp_op2 SHALL be stable while resp_val=1 and resp_rdy=0, except for updates under REQ-020.

Reset
REQ-025 rst SHALL force the state to IDLE and clear all latched fields and operands to 0, with priority over all other activity.
REQ-026 During and after reset: req_rdy=1 (from the first cycle after reset), resp_val=0, rf_raddr=0, resp_op1=resp_op2=0.
REQ-027 Reset asserted mid-operation (RD1, RD2 or RESP) SHALL abort the transaction with no response.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the widths (address 5, data 32).
REQ-029 The block SHALL be a single module; the register file instance SHALL live in the parent and not in this block.

Verification
REQ-030 Preload x3=0x11, x4=0x22; request rs1=3, rs2=4, two=1 -> raddr 3 then 4; resp in cycle 3 with op1=0x11, op2=0x22.
REQ-031 Request rs1=5 (x5=0xAA), two=0 -> resp in cycle 2 with op1=0xAA, op2=0.
REQ-032 In RD1 reading x7, apply a same-cycle write x7=0x99 -> op1=0x99, not the old value.
REQ-033 Request rs1=0, rs2=0 with a same-cycle write of 0x55 to x0 -> op1=op2=0.
REQ-034 Hold resp_rdy=0 for 3 cycles in RESP and write x3=0x77 (rs1=rs2=3) -> op1=op2=0x77; resp_val stays high; IDLE after resp_rdy=1.
REQ-035 Assert rst in RD2 -> next cycle IDLE, resp_val=0, all outputs 0, and no response ever appears for the aborted request.
